// File: rtl/dc_block_pkg.sv
// Shared types and helpers for the time-multiplexed DC blocker.
package dc_block_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Largest alpha exponent; larger shift requests are clamped to this.
   localparam int unsigned SHIFT_MAX = 12;

   // Widest sample the saturation helper supports. Callers sign-extend
   // into it and keep the low W bits of the result.
   localparam int unsigned SAT_MAX_W = 32;

   // Saturate a signed value to the w-bit two's complement range.
   function automatic logic signed [SAT_MAX_W-1:0] sat_w(
      input logic signed [SAT_MAX_W+1:0] v,
      input int unsigned                 w
   );
      logic signed [SAT_MAX_W+1:0] hi;
      logic signed [SAT_MAX_W+1:0] lo;
      hi = (34'sd1 <<< (w - 1)) - 34'sd1;
      lo = -hi - 34'sd1;
      if (v > hi)
         return hi[SAT_MAX_W-1:0];
      else if (v < lo)
         return lo[SAT_MAX_W-1:0];
      else
         return v[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/dc_block_alu.sv
// Combinational datapath of the shared DC blocker core. Produces the
// feedback product for the MUL step and the saturated output for the ACC
// step; the product register between them lives in the scheduler.
module dc_block_alu
   import dc_block_pkg::*;
#(
   parameter int W = 16
) (
   input  logic signed [W-1:0]   x,
   input  logic signed [W-1:0]   x_prev,
   input  logic signed [W-1:0]   y_prev,
   input  logic signed [2*W-1:0] prod,
   input  logic        [3:0]     s,
   output logic signed [2*W-1:0] mul,
   output logic signed [W-1:0]   y
);

   logic signed [2*W-1:0]       coef;
   logic signed [2*W-1:0]       shifted;
   logic signed [W:0]           diff;
   logic signed [W+1:0]         sum;
   logic signed [SAT_MAX_W-1:0] y_full;

   // Feedback product y_prev*(2^S-1) and the saturated difference-plus-feedback.
   // NOTE: every output of a combinational block is assigned on every pass, so no latch is inferred.
   always_comb begin
      coef    = $signed(((2*W)'(1) << s) - (2*W)'(1));
      mul     = (2*W)'(y_prev) * coef;
      diff    = (W+1)'(x) - (W+1)'(x_prev);
      // Arithmetic shift: rounds toward negative infinity. |prod>>>S| < 2^(W-1),
      // so the low W+2 bits carry the full value.
      shifted = prod >>> s;
      sum     = (W+2)'(diff) + $signed(shifted[W+1:0]);
      y_full  = sat_w((SAT_MAX_W+2)'(sum), W);
      y       = y_full[W-1:0];
   end

endmodule

// File: rtl/dc_block_sched.sv
// Time-multiplexed multi-channel DC blocker. Each accepted frame is run
// channel by channel through one shared multiply/accumulate core, two
// cycles per channel, followed by a single DONE cycle that publishes it.
module dc_block_sched
   import dc_block_pkg::*;
#(
   parameter int W    = 16,
   parameter int N_CH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_strobe,
   input  logic [N_CH*W-1:0]   sample_in,
   input  logic [N_CH-1:0]     bypass,
   input  logic [3:0]          shift,
   output logic [N_CH*W-1:0]   sample_out,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   state_t                state;
   logic [CH_W-1:0]       ch;
   logic signed [W-1:0]   x_lat   [N_CH];
   logic signed [W-1:0]   x_prev  [N_CH];
   logic signed [W-1:0]   y_prev  [N_CH];
   logic signed [W-1:0]   out_buf [N_CH];
   logic [N_CH-1:0]       byp_lat;
   logic [3:0]            s_lat;
   logic [3:0]            shift_clamped;
   logic signed [2*W-1:0] prod;
   logic signed [2*W-1:0] mul;
   logic signed [W-1:0]   y_alu;

   assign shift_clamped = (shift > 4'(SHIFT_MAX)) ? 4'(SHIFT_MAX) : shift;

   dc_block_alu #(.W(W)) u_alu (
      .x      (x_lat[ch]),
      .x_prev (x_prev[ch]),
      .y_prev (y_prev[ch]),
      .prod   (prod),
      .s      (s_lat),
      .mul    (mul),
      .y      (y_alu)
   );

   // Frame scheduler: accept in IDLE, alternate MUL/ACC per channel, publish in DONE.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ch         <= '0;
         prod       <= '0;
         byp_lat    <= '0;
         s_lat      <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         // NOTE: channel state is a small flop array, so it is reset explicitly;
         // a RAM-based store would need a clearing sweep instead.
         for (int c = 0; c < N_CH; c++) begin
            x_lat[c]   <= '0;
            x_prev[c]  <= '0;
            y_prev[c]  <= '0;
            out_buf[c] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (sample_strobe && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (sample_strobe) begin
                  for (int c = 0; c < N_CH; c++)
                     x_lat[c] <= sample_in[c*W +: W];
                  byp_lat <= bypass;
                  s_lat   <= shift_clamped;
                  ch      <= '0;
                  busy    <= 1'b1;
                  state   <= MUL;
               end
            end
            MUL: begin
               prod  <= mul;
               state <= ACC;
            end
            ACC: begin
               x_prev[ch] <= x_lat[ch];
               if (byp_lat[ch]) begin
                  // Bypass passes the input through and zeroes the feedback,
                  // so leaving bypass later produces no step.
                  out_buf[ch] <= x_lat[ch];
                  y_prev[ch]  <= '0;
               end else begin
                  out_buf[ch] <= y_alu;
                  y_prev[ch]  <= y_alu;
               end
               if (ch == LAST_CH) begin
                  state <= DONE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= MUL;
               end
            end
            DONE: begin
               for (int c = 0; c < N_CH; c++)
                  sample_out[c*W +: W] <= out_buf[c];
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dc_block_sched.sv
// Self-checking bench for dc_block_sched: directed scenarios plus random
// frames, compared against an arithmetic model of the filter recurrence.
module tb_dc_block_sched;

   localparam int W    = 16;
   localparam int N_CH = 4;
   localparam int LAT  = 2*N_CH + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_strobe;
   logic [N_CH*W-1:0] sample_in;
   logic [N_CH-1:0]   bypass;
   logic [3:0]        shift;
   logic [N_CH*W-1:0] sample_out;
   logic              out_valid;
   logic              busy;
   logic              overrun;

   dc_block_sched #(.W(W), .N_CH(N_CH)) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_strobe (sample_strobe),
      .sample_in     (sample_in),
      .bypass        (bypass),
      .shift         (shift),
      .sample_out    (sample_out),
      .out_valid     (out_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: previous input, previous output, last published output.
   int cur_x [N_CH];
   int m_xp  [N_CH];
   int m_yp  [N_CH];
   int m_out [N_CH];
   int seq   [4][N_CH];

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd_s();
      return int'($signed(W'($urandom)));
   endfunction

   function automatic int dut_ch(input int c);
      return int'($signed(sample_out[c*W +: W]));
   endfunction

   // floor(a / 2^s) for signed a.
   function automatic longint floor_shift(input longint a, input int s);
      longint d;
      longint q;
      d = longint'(1) << s;
      q = a / d;
      if ((a % d) != 0 && a < 0)
         q = q - 1;
      return q;
   endfunction

   function automatic int clamp_w(input longint v);
      longint hi;
      hi = (longint'(1) << (W-1)) - 1;
      if (v > hi) return int'(hi);
      if (v < -hi - 1) return int'(-hi - 1);
      return int'(v);
   endfunction

   // One frame of y = (x - x_prev) + alpha*y_prev with alpha = (2^S-1)/2^S.
   function automatic void model_frame(input logic [N_CH-1:0] byp, input int sh);
      int     s;
      longint p;
      longint sum;
      s = (sh > 12) ? 12 : sh;
      for (int c = 0; c < N_CH; c++) begin
         if (byp[c]) begin
            m_out[c] = cur_x[c];
            m_yp[c]  = 0;
         end else begin
            p        = longint'(m_yp[c]) * ((longint'(1) << s) - 1);
            sum      = longint'(cur_x[c] - m_xp[c]) + floor_shift(p, s);
            m_out[c] = clamp_w(sum);
            m_yp[c]  = m_out[c];
         end
         m_xp[c] = cur_x[c];
      end
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_xp[c]  = 0;
         m_yp[c]  = 0;
         m_out[c] = 0;
      end
   endfunction

   task automatic drive_frame();
      for (int c = 0; c < N_CH; c++)
         sample_in[c*W +: W] = W'(cur_x[c]);
   endtask

   // Called #1 after a clock edge with the DUT idle. Sends cur_x, optionally
   // injects a second strobe drop_at cycles after acceptance, waits for out_valid.
   task automatic run_frame(input logic [N_CH-1:0] byp, input logic [3:0] sh,
                            input int drop_at);
      logic [N_CH*W-1:0] hold;
      int                seen;
      int                stable;
      drive_frame();
      bypass        = byp;
      shift         = sh;
      sample_strobe = 1'b1;
      hold          = sample_out;
      @(posedge clk); #1;
      sample_strobe = 1'b0;
      model_frame(byp, int'(sh));
      check("busy_after_accept", int'(busy), 1);
      seen   = -1;
      stable = 1;
      for (int cyc = 1; cyc <= LAT + 6; cyc++) begin
         if (drop_at > 0 && cyc == drop_at) begin
            sample_in     = {$urandom, $urandom};
            bypass        = N_CH'($urandom);
            shift         = 4'($urandom);
            sample_strobe = 1'b1;
         end
         if (drop_at > 0 && cyc == drop_at + 1)
            sample_strobe = 1'b0;
         @(posedge clk); #1;
         if (out_valid) begin
            seen = cyc;
            break;
         end
         if (sample_out !== hold)
            stable = 0;
      end
      check("latency", seen, LAT);
      check("held_between_pulses", stable, 1);
      check("busy_after_done", int'(busy), 0);
      for (int c = 0; c < N_CH; c++)
         check($sformatf("ch%0d_out", c), dut_ch(c), m_out[c]);
   endtask

   task automatic rand_frame();
      for (int c = 0; c < N_CH; c++)
         cur_x[c] = rnd_s();
   endtask

   int exp_pos [3] = '{1000, 996, 992};
   int exp_neg [3] = '{-1000, -997, -994};
   int pulses;

   initial begin
      rst           = 1'b1;
      sample_strobe = 1'b0;
      sample_in     = '0;
      bypass        = '0;
      shift         = '0;
      model_reset();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_sample_out", int'(sample_out != '0), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // A full frame to make state non-zero, then reset during MUL of channel 2.
      rand_frame();
      run_frame('0, 4'd6, 0);
      rand_frame();
      drive_frame();
      sample_strobe = 1'b1;
      @(posedge clk); #1;
      sample_strobe = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_sample_out", int'(sample_out != '0), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("midrst_no_valid", pulses, 0);

      // DC step at +1000 from clean state.
      for (int k = 0; k < 3; k++) begin
         rand_frame();
         cur_x[0] = 1000;
         run_frame('0, 4'd8, 0);
         check("dc_pos", dut_ch(0), exp_pos[k]);
      end

      // Clear channel 0 through bypass, then DC step at -1000.
      rand_frame();
      cur_x[0] = 0;
      run_frame(4'b0001, 4'd8, 0);
      for (int k = 0; k < 3; k++) begin
         rand_frame();
         cur_x[0] = -1000;
         run_frame('0, 4'd8, 0);
         check("dc_neg", dut_ch(0), exp_neg[k]);
      end

      // Saturation: ch1 full-scale negative to full-scale positive with y_prev = 0.
      rand_frame();
      cur_x[1] = -32768;
      run_frame(4'b0010, 4'd8, 0);
      rand_frame();
      cur_x[1] = 32767;
      run_frame('0, 4'd8, 0);
      check("sat_pos", dut_ch(1), 32767);

      // Bypass ch2 at 5000, then un-bypass with the same input.
      rand_frame();
      cur_x[2] = 5000;
      run_frame(4'b0100, 4'd8, 0);
      check("bypass_pass", dut_ch(2), 5000);
      rand_frame();
      cur_x[2] = 5000;
      run_frame('0, 4'd8, 0);
      check("bypass_no_step", dut_ch(2), 0);

      // Shift clamp: the same sequence with shift 15 and shift 12.
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < N_CH; c++)
            seq[k][c] = rnd_s();
      for (int pass = 0; pass < 2; pass++) begin
         for (int c = 0; c < N_CH; c++) cur_x[c] = 77 * (c + 1);
         run_frame('1, 4'd12, 0);
         for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < N_CH; c++) cur_x[c] = seq[k][c];
            run_frame('0, (pass == 0) ? 4'd15 : 4'd12, 0);
         end
      end

      // Shift 0: pure differentiator, constant input gives zero after the first frame.
      rand_frame();
      for (int k = 0; k < 3; k++) begin
         run_frame('0, 4'd0, 0);
         if (k > 0)
            for (int c = 0; c < N_CH; c++)
               check("shift0_zero", dut_ch(c), 0);
      end

      // Random frames at minimum strobe spacing.
      for (int k = 0; k < 25; k++) begin
         rand_frame();
         if (k % 5 == 0) cur_x[$urandom_range(N_CH-1)] = -32768;
         if (k % 7 == 0) cur_x[$urandom_range(N_CH-1)] = 32767;
         run_frame(N_CH'($urandom), 4'($urandom), 0);
      end
      check("no_spurious_overrun", int'(overrun), 0);

      // Overrun: second strobe 3 cycles after accept is dropped.
      rand_frame();
      run_frame(N_CH'($urandom), 4'd8, 3);
      check("overrun_set", int'(overrun), 1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("overrun_single_valid", pulses, 0);
      for (int c = 0; c < N_CH; c++)
         check("overrun_first_frame", dut_ch(c), m_out[c]);
      check("overrun_sticky", int'(overrun), 1);

      // Only reset clears overrun.
      rst = 1'b1;
      #1;
      check("overrun_cleared", int'(overrun), 0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
